// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response and
// decode-side valid/ready. The fetch unit takes the master side.
interface fetch_prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, occupancy
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues sequential word fetches under a credit limit,
// buffers in-order responses in a prefetch queue, and flushes on redirect.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [OCC_W-1:0]  count_reg, count_next;
  logic [OCC_W-1:0]  outstanding_reg, outstanding_next;
  logic [OCC_W-1:0]  drop_cnt_reg, drop_cnt_next;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic              accept;
  logic              resp_ok;
  logic              drop;
  logic              push;
  logic              pop;
  logic [OCC_W:0]    credit_used;
  logic [ADDR_W-1:0] target_pc;
  logic              unused_low_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign target_pc       = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_low_bits = &{1'b0, bus.redirect_pc[1:0]};

  // Every queued entry or in-flight request holds one slot, so a push can never overflow.
  assign credit_used  = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign bus.imem_req = !reset && !bus.redirect_valid && (credit_used < (OCC_W+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc_reg;

  assign accept  = bus.imem_req && bus.imem_ready;
  assign resp_ok = bus.imem_rvalid && (outstanding_reg != '0);
  assign drop    = resp_ok && (drop_cnt_reg != '0);
  assign push    = resp_ok && !drop;
  assign pop     = bus.inst_valid && bus.inst_ready;

  assign bus.inst_valid = (count_reg != '0);
  assign bus.inst       = inst_mem[rd_ptr_reg];
  assign bus.inst_pc    = pc_mem[rd_ptr_reg];
  assign bus.occupancy  = count_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    count_next       = count_reg;
    drop_cnt_next    = drop_cnt_reg;
    outstanding_next = outstanding_reg + OCC_W'(accept) - OCC_W'(resp_ok);

    if (bus.redirect_valid) begin
      // Whatever is still in flight after this cycle belongs to the old path.
      fetch_pc_next = target_pc;
      resp_pc_next  = target_pc;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
      drop_cnt_next = outstanding_next;
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + ADDR_W'(4);
        wr_ptr_next  = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (drop) begin
        drop_cnt_next = drop_cnt_reg - OCC_W'(1);
      end
      count_next = count_reg + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  // Queue storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push && !bus.redirect_valid) begin
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
      inst_mem[wr_ptr_reg] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model with variable latency,
// scoreboards for request addresses and delivered instructions, directed checks.
module tb_fetch_prefetch_unit;
  localparam logic [31:0] SCRAMBLE = 32'hA5A5_A5A5;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat      = 1;
  int   acc_cnt  = 0;
  int   pop_cnt  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_inst[$];

  fetch_prefetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus ();

  fetch_prefetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_req.size() != 0 || exp_inst.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_req.size() != 0 || exp_inst.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=pending req %0d inst %0d required=0 after %0d cycles",
               name, exp_req.size(), exp_inst.size(), n);
    end
  endtask

  task automatic start_redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    exp_req.delete();
    exp_inst.delete();
  endtask

  // In-order memory: accepts are recorded on the negedge before the edge that takes them.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_q.delete();
      end else begin
        if (bus.imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (bus.imem_req && bus.imem_ready) mem_q.push_back('{bus.imem_addr, cyc + lat});
      end
      @(posedge clk);
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_q[0].addr ^ SCRAMBLE;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  // Monitor: one line per accepted request and per consumed instruction.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !bus.redirect_valid) begin
        if (bus.imem_req && bus.imem_ready) begin
          acc_cnt++;
          if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            chk("req_addr", bus.imem_addr, e);
          end
        end
        if (bus.inst_valid && bus.inst_ready) begin
          pop_cnt++;
          if (exp_inst.size() > 0) begin
            e = exp_inst.pop_front();
            chk("inst_pc", bus.inst_pc, e);
            chk("inst_data", bus.inst, e ^ SCRAMBLE);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ready     = 1'b1;
    bus.inst_ready     = 1'b1;
    lat                = 1;
    repeat (3) tick();

    // Reset state, then sequential fetch with a 1-cycle memory.
    @(negedge clk);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.inst_valid, 1'b0);
    chk("rst_occ", bus.occupancy, 0);
    tick();
    reset   = 1'b0;
    acc_cnt = 0;
    exp_req  = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_inst = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    @(negedge clk);
    chk("first_req", bus.imem_req, 1'b1);
    chk("valid_c0", bus.inst_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("valid_c1", bus.inst_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("valid_c2", bus.inst_valid, 1'b1);
    tick();
    chk("acc_consec", acc_cnt, 3);
    wait_drain("seq");

    // Fill the queue with decode stalled, then release exactly one pop.
    tick();
    start_redirect(32'h100);
    bus.inst_ready = 1'b0;
    exp_req = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    acc_cnt = 0;
    pop_cnt = 0;
    @(negedge clk);
    chk("redir_noreq", bus.imem_req, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("full_occ", bus.occupancy, 4);
    chk("full_req", bus.imem_req, 1'b0);
    tick();
    chk("full_acc", acc_cnt, 4);
    exp_inst.push_back(32'h100);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    repeat (5) tick();
    chk("refill_acc", acc_cnt, 5);
    chk("one_pop", pop_cnt, 1);
    @(negedge clk);
    chk("refill_occ", bus.occupancy, 4);
    chk("refill_req", bus.imem_req, 1'b0);

    // 3-cycle memory: redirect with two requests in flight.
    tick();
    start_redirect(32'h200);
    lat            = 3;
    bus.inst_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) tick();
    chk("outstanding2", mem_q.size(), 2);
    start_redirect(32'h0000_0402);
    exp_req  = '{32'h400, 32'h404, 32'h408};
    exp_inst = '{32'h400, 32'h404, 32'h408, 32'h40C};
    @(negedge clk);
    chk("redir2_noreq", bus.imem_req, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    wait_drain("drop");

    // Memory stalls for 5 cycles: address must hold.
    tick();
    start_redirect(32'h800);
    lat            = 1;
    bus.imem_ready = 1'b0;
    exp_req  = '{32'h800, 32'h804, 32'h808};
    exp_inst = '{32'h800, 32'h804, 32'h808};
    tick();
    bus.redirect_valid = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req", bus.imem_req, 1'b1);
      chk("hold_addr", bus.imem_addr, 32'h800);
      tick();
    end
    chk("hold_acc", acc_cnt, 0);
    chk("hold_occ", bus.occupancy, 0);
    bus.imem_ready = 1'b1;
    wait_drain("stall");

    // Address wrap at the top of the space.
    tick();
    start_redirect(32'hFFFF_FFF8);
    exp_req  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_inst = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    tick();
    bus.redirect_valid = 1'b0;
    wait_drain("wrap");

    // Reset with three queued entries and one request in flight.
    tick();
    start_redirect(32'hC00);
    bus.inst_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !(bus.occupancy == 3 && mem_q.size() == 1); i++) tick();
    chk("pre_rst_occ", bus.occupancy, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("in_rst_req", bus.imem_req, 1'b0);
    tick();
    @(negedge clk);
    chk("rst2_valid", bus.inst_valid, 1'b0);
    chk("rst2_occ", bus.occupancy, 0);
    chk("rst2_req", bus.imem_req, 1'b0);
    tick();
    reset = 1'b0;
    exp_req.delete();
    exp_inst.delete();
    exp_req  = '{32'h0, 32'h4};
    exp_inst = '{32'h0, 32'h4};
    bus.inst_ready = 1'b1;
    wait_drain("rst_restart");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage for the 32-bit MIPS pipeline. It owns the fetch PC and issues sequential word requests to instruction memory over a request/ready + in-order response interface. Responses are buffered in a DEPTH-entry prefetch queue, which is drained by decode through a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
DEPTH, 4, prefetch queue entries; also the cap on outstanding requests (must be ≥2)
RESET_PC, 32'h0000_0000, PC after reset (word aligned)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  ADDR_W  new fetch target; bits [1:0] ignored, forced to 0
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request word address
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (in order, ≥1 cycle after acceptance)
imem_rdata  in  DATA_W  response instruction
inst_valid  out  1  queue head valid
inst  out  DATA_W  head instruction
inst_pc  out  ADDR_W  address of head instruction
inst_ready  in  1  decode consumes head
occupancy  out  clog2(DEPTH+1)  current queue entries

Behaviour:
- State: fetch_pc, resp_pc, queue (DEPTH × {pc, inst}), rd/wr pointers, count, outstanding, drop_cnt.
- Reset (synchronous, sampled at clk edge): fetch_pc = resp_pc = RESET_PC; count = outstanding = drop_cnt = 0; inst_valid = 0; occupancy = 0; imem_req = 0 while reset is high. Reset overrides every other input. The instruction memory shares reset and discards its in-flight responses.
- Request: imem_req = !reset && !redirect_valid && (count + outstanding < DEPTH). imem_addr = fetch_pc and holds stable while imem_req && !imem_ready.
- Accept (imem_req && imem_ready): fetch_pc += 4 (modulo 2^ADDR_W, so 0xFFFFFFFC → 0); outstanding += 1.
- First request is issued in the first cycle after reset deasserts.
- Response (imem_rvalid):
  - outstanding −= 1.
  - If drop_cnt > 0: drop_cnt −= 1 and the data is discarded.
  - Otherwise push {resp_pc, imem_rdata} and resp_pc += 4.
  - Acceptance and response in the same cycle leave outstanding net unchanged.
  - A response with outstanding == 0 is a protocol error and is ignored.
- The credit rule guarantees a push never meets a full queue.
- Decode side:
  - inst_valid = (count ≠ 0); inst and inst_pc come from the head entry and are registered, with no combinational path from imem_rdata.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle keep count unchanged. A push into an empty queue becomes visible the next cycle, so minimum memory-to-decode latency is 1 cycle.
- Redirect (redirect_valid = 1), which has priority over push/pop:
  - fetch_pc = resp_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Queue cleared (count = 0, pointers reset).
  - drop_cnt = outstanding − (imem_rvalid ? 1 : 0) + (drop_cnt adjustment), i.e. every response not yet returned at the end of this cycle is dropped. A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle. Requests restart the next cycle, provided outstanding < DEPTH.
  - A pop in the redirect cycle is legal; the head is considered consumed.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- Invariants:
  - count + outstanding ≤ DEPTH.
  - drop_cnt ≤ outstanding.
  - occupancy = count.

Test Plan:
- Reset to RESET_PC=0, imem_ready=1, 1-cycle memory, inst_ready=1 → imem_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8 in order with matching inst; inst_valid first rises 2 cycles after the first accept.
- DEPTH=4, inst_ready=0, imem_ready=1 → exactly 4 accepts, then imem_req=0 with occupancy=4. Raise inst_ready for 1 cycle → one pop, one new request.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x0000_0402 → next imem_addr=0x400; the 2 stale responses are dropped; first inst_pc delivered is 0x400.
- imem_ready=0 for 5 cycles with imem_req=1 → imem_addr held at the same value; fetch_pc does not advance; no responses; resumes in order once ready.
- redirect_pc=0xFFFF_FFF8 → imem_addr sequence FFFFFFF8, FFFFFFFC, 00000000; inst_pc follows the same wrap.
- Reset asserted with queue=3 and outstanding=1 → next cycle inst_valid=0, occupancy=0, imem_req=0; after release, first imem_addr=RESET_PC.
